load_store_initiator: RTL and testbench
=======================================

LOAD_STORE_INITIATOR -- requirements
Module: load_store_initiator

Interface
REQ-001 Parameter TRACK_DEPTH, default 16: maximum outstanding memory requests; power of two.
REQ-002 Parameter TAG_W, default 6: width of the ROB tag carried with each request.
REQ-003 Ports, clock and reset first. Clock: clk, one clock. Reset: reset, asynchronous, active-low.
REQ-004 clk  in  1  sole clock; every flop is rising-edge triggered.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  upstream handshake; a request transfers when both are high on a clk edge.
REQ-007 req_load_store  in  1  1 = load, 0 = store.
REQ-008 req_BMS  in  1  1 = byte access, 0 = word access.
REQ-009 req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_address, req_store_value  in  32, 32  byte address and store data; only bits [7:0] are used for byte stores.
REQ-011 req_tag  in  TAG_W  ROB tag.
REQ-012 mem_valid, mem_load_store, mem_BMS, mem_address, mem_store_value  out  1,1,1,32,32  request to the fixed-latency memory.
REQ-013 mem_valid_in, mem_load_store_in, mem_address_in, mem_load_value_in  in  1,1,32,32  memory response; responses return in issue order.
REQ-014 result_valid, result_is_load, result_tag, result_value  out  1,1,TAG_W,32  completion broadcast; there is no backpressure.
REQ-015 proto_error  out  1  sticky error flag.

Function
REQ-016 At most one memory request is issued per cycle; mem_* outputs are registered and valid for one cycle per request.
REQ-017 An accepted word load, word store or byte load is issued on the cycle after acceptance, with its fields passed through unchanged.
REQ-018 Each issued request pushes a tracking entry {tag, is_load, BMS, signed, internal} into an in-order FIFO of TRACK_DEPTH entries.
REQ-019 Each mem_valid_in pops the head entry. result_* are registered one cycle later:
- Loads: result_value = mem_load_value_in, or for a byte load [7:0] sign- or zero-extended per the entry.
- Stores: result_value = 0, result_is_load = 0.
REQ-020 A popped entry with internal = 1 produces no result_valid.
REQ-021 Byte stores use a read-modify-write FSM with three states.
- IDLE: a byte-store request is accepted.
- RMW_LOAD_WAIT: an internal word load to the same address is issued; the FSM waits for its response at the FIFO head.
- RMW_STORE: a word store is issued carrying the loaded word with [7:0] replaced by the store byte. The tracking entry holds the original tag, internal = 0. The FSM then returns to IDLE.
REQ-022 req_ready = (state == IDLE) && (count < TRACK_DEPTH).
REQ-023 A push and a pop in the same cycle leave count unchanged.
REQ-024 An upstream request and the RMW_STORE issue never coincide.
REQ-025 Word stores write all four bytes little-endian at address..address+3; byte stores change exactly one byte.
REQ-026 proto_error sets and holds until reset when:
- mem_valid_in arrives with the FIFO empty; or
- mem_load_store_in differs from the head entry's is_load; or
- mem_address_in differs from the head's recorded address.
REQ-027 On an erroneous response with a non-empty FIFO, the head is still popped; result_valid is suppressed for that response.

Reset
REQ-028 While reset is low, every output is 0, the FIFO is empty, count = 0, state = IDLE, and proto_error = 0.
REQ-029 Reset mid-operation discards all in-flight tracking. Responses arriving after reset release with an empty FIFO raise proto_error.

Structure
REQ-030 A shared package holds: the FSM state enum, the tracking-entry struct, TAG_W, TRACK_DEPTH, and the load/store encoding constants.
REQ-031 The tracking FIFO is one sub-module, lsu_track_fifo, parameterised by depth and entry width.

Verification
REQ-032 Word store 0xDEADBEEF @0x40 tag 3, then word load @0x40 tag 4 -> result tag 3 (is_load 0), then tag 4 with value 0xDEADBEEF.
REQ-033 After REQ-032, byte store 0xAB @0x41 tag 5 -> one internal load and one store issued, req_ready low throughout, single result tag 5; word load @0x40 returns 0xDEADABEF.
REQ-034 Byte load @0x41 with signed = 1 -> 0xFFFFFFAB; with signed = 0 -> 0x000000AB.
REQ-035 Stalling memory model holds responses; 16 loads accepted -> req_ready low. Next response pops -> req_ready high the following cycle; all 16 results return in order.
REQ-036 Inject mem_valid_in with the FIFO empty -> proto_error = 1 and no result_valid; proto_error stays high until reset.
REQ-037 Assert reset with 5 requests in flight -> all outputs 0 immediately. After release, count = 0 and a new word load completes normally.

Source files
------------

// File: rtl/load_store_initiator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_initiator_pkg
//  Description : Shared types and constants for the load/store initiator:
//                RMW state encoding, tracking-entry metadata, defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_initiator_pkg;

   localparam int DEF_TAG_W       = 6;
   localparam int DEF_TRACK_DEPTH = 16;

   localparam logic OP_LOAD  = 1'b1;
   localparam logic OP_STORE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_RMW_LOAD_WAIT = 2'd1,
      ST_RMW_STORE     = 2'd2
   } rmw_state_t;

   // Per-request tracking metadata. The tag travels alongside this struct
   // so each instance can choose its own TAG_W.
   typedef struct packed {
      logic        is_load;
      logic        bms;
      logic        sgn;
      logic        internal;
      logic [31:0] address;
   } track_meta_t;

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sgn);
      return {{24{sgn & b[7]}}, b};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_track_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_track_fifo
//  Description : In-order tracking FIFO for outstanding memory requests.
//                DEPTH must be a power of two (pointers wrap naturally).
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_track_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = storage[rd_ptr];

   // Pointer and occupancy tracking; simultaneous push and pop keep count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push) storage[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/load_store_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_initiator
//  Description : Issues loads/stores to a fixed-latency, in-order memory,
//                tracks them in a FIFO and broadcasts completions. Byte
//                stores are performed as a word read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_initiator
   import load_store_initiator_pkg::*;
#(
   parameter int TRACK_DEPTH = DEF_TRACK_DEPTH,
   parameter int TAG_W       = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_load_store,
   input  logic             req_BMS,
   input  logic             req_signed,
   input  logic [31:0]      req_address,
   input  logic [31:0]      req_store_value,
   input  logic [TAG_W-1:0] req_tag,
   output logic             mem_valid,
   output logic             mem_load_store,
   output logic             mem_BMS,
   output logic [31:0]      mem_address,
   output logic [31:0]      mem_store_value,
   input  logic             mem_valid_in,
   input  logic             mem_load_store_in,
   input  logic [31:0]      mem_address_in,
   input  logic [31:0]      mem_load_value_in,
   output logic             result_valid,
   output logic             result_is_load,
   output logic [TAG_W-1:0] result_tag,
   output logic [31:0]      result_value,
   output logic             proto_error
);
   localparam int META_W  = $bits(track_meta_t);
   localparam int ENTRY_W = TAG_W + META_W;
   localparam int CNT_W   = $clog2(TRACK_DEPTH) + 1;

   rmw_state_t         state, state_next;
   logic               accept;
   logic               issue;
   logic               issue_ls;
   logic               issue_bms;
   logic [31:0]        issue_addr;
   logic [31:0]        issue_data;
   logic [TAG_W-1:0]   push_tag;
   track_meta_t        push_meta;
   logic [ENTRY_W-1:0] head_data;
   logic [TAG_W-1:0]   head_tag;
   track_meta_t        head_meta;
   logic               fifo_empty;
   logic [CNT_W-1:0]   count;
   logic               pop;
   logic               resp_err;
   logic [31:0]        resp_value;
   logic [TAG_W-1:0]   rmw_tag;
   logic [31:0]        rmw_addr;
   logic [7:0]         rmw_byte;
   logic [31:0]        rmw_word;

   // Outputs are forced low while reset is asserted, including this one
   assign req_ready  = reset && (state == ST_IDLE) && (count < CNT_W'(TRACK_DEPTH));
   assign accept     = req_valid && req_ready;
   assign pop        = mem_valid_in && !fifo_empty;
   assign head_tag   = head_data[ENTRY_W-1 -: TAG_W];
   assign head_meta  = track_meta_t'(head_data[META_W-1:0]);
   assign resp_err   = mem_valid_in && (fifo_empty ||
                                        (mem_load_store_in != head_meta.is_load) ||
                                        (mem_address_in != head_meta.address));
   assign resp_value = !head_meta.is_load ? 32'd0 :
                       head_meta.bms ? extend_byte(mem_load_value_in[7:0], head_meta.sgn) :
                                       mem_load_value_in;

   lsu_track_fifo #(
      .DEPTH (TRACK_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_track_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (issue),
      .push_data ({push_tag, push_meta}),
      .pop       (pop),
      .head_data (head_data),
      .empty     (fifo_empty),
      .count     (count)
   );

   // RMW state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Issue selection and next state: byte stores start with an internal word load
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      issue_ls   = OP_STORE;
      issue_bms  = 1'b0;
      issue_addr = '0;
      issue_data = '0;
      push_tag   = '0;
      push_meta  = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               issue      = 1'b1;
               issue_addr = req_address;
               push_tag   = req_tag;
               if (req_load_store == OP_STORE && req_BMS) begin
                  issue_ls   = OP_LOAD;
                  push_meta  = '{is_load: 1'b1, bms: 1'b0, sgn: 1'b0,
                                 internal: 1'b1, address: req_address};
                  state_next = ST_RMW_LOAD_WAIT;
               end else begin
                  issue_ls   = req_load_store;
                  issue_bms  = req_BMS;
                  issue_data = req_store_value;
                  push_meta  = '{is_load: req_load_store, bms: req_BMS, sgn: req_signed,
                                 internal: 1'b0, address: req_address};
               end
            end
         end
         ST_RMW_LOAD_WAIT: begin
            if (pop && head_meta.internal) state_next = ST_RMW_STORE;
         end
         ST_RMW_STORE: begin
            issue      = 1'b1;
            issue_ls   = OP_STORE;
            issue_addr = rmw_addr;
            issue_data = rmw_word;
            push_tag   = rmw_tag;
            push_meta  = '{is_load: 1'b0, bms: 1'b0, sgn: 1'b0,
                           internal: 1'b0, address: rmw_addr};
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Registered memory request, one-cycle pulse per issue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_valid       <= 1'b0;
         mem_load_store  <= 1'b0;
         mem_BMS         <= 1'b0;
         mem_address     <= '0;
         mem_store_value <= '0;
      end else begin
         mem_valid <= issue;
         if (issue) begin
            mem_load_store  <= issue_ls;
            mem_BMS         <= issue_bms;
            mem_address     <= issue_addr;
            mem_store_value <= issue_data;
         end
      end
   end

   // Completion broadcast and sticky protocol error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_valid   <= 1'b0;
         result_is_load <= 1'b0;
         result_tag     <= '0;
         result_value   <= '0;
         proto_error    <= 1'b0;
      end else begin
         result_valid <= pop && !head_meta.internal && !resp_err;
         if (pop) begin
            result_is_load <= head_meta.is_load;
            result_tag     <= head_tag;
            result_value   <= resp_value;
         end
         proto_error <= proto_error | resp_err;
      end
   end

   // Byte-store context: captured on acceptance, merged word built from the internal load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rmw_tag  <= '0;
         rmw_addr <= '0;
         rmw_byte <= '0;
         rmw_word <= '0;
      end else begin
         if (state == ST_IDLE && accept && req_load_store == OP_STORE && req_BMS) begin
            rmw_tag  <= req_tag;
            rmw_addr <= req_address;
            rmw_byte <= req_store_value[7:0];
         end
         if (state == ST_RMW_LOAD_WAIT && pop && head_meta.internal) begin
            rmw_word <= {mem_load_value_in[31:8], rmw_byte};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_initiator
//  Description : Directed scoreboard bench for load_store_initiator with a
//                byte-addressed in-order memory model that can stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_initiator;
   localparam int TAG_W = 6;
   localparam int LAT   = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_load_store = 1'b0;
   logic             req_BMS = 1'b0;
   logic             req_signed = 1'b0;
   logic [31:0]      req_address = '0;
   logic [31:0]      req_store_value = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             mem_valid, mem_load_store, mem_BMS;
   logic [31:0]      mem_address, mem_store_value;
   logic             mem_valid_in = 1'b0;
   logic             mem_load_store_in = 1'b0;
   logic [31:0]      mem_address_in = '0;
   logic [31:0]      mem_load_value_in = '0;
   logic             result_valid, result_is_load;
   logic [TAG_W-1:0] result_tag;
   logic [31:0]      result_value;
   logic             proto_error;

   load_store_initiator #(.TRACK_DEPTH(16), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_load_store(req_load_store), .req_BMS(req_BMS), .req_signed(req_signed),
      .req_address(req_address), .req_store_value(req_store_value), .req_tag(req_tag),
      .mem_valid(mem_valid), .mem_load_store(mem_load_store), .mem_BMS(mem_BMS),
      .mem_address(mem_address), .mem_store_value(mem_store_value),
      .mem_valid_in(mem_valid_in), .mem_load_store_in(mem_load_store_in),
      .mem_address_in(mem_address_in), .mem_load_value_in(mem_load_value_in),
      .result_valid(result_valid), .result_is_load(result_is_load),
      .result_tag(result_tag), .result_value(result_value),
      .proto_error(proto_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic             is_load;
      logic [31:0]      value;
   } res_t;

   typedef struct {
      logic        ls;
      logic [31:0] addr;
      logic [31:0] val;
      int          due;
   } resp_t;

   int checks = 0;
   int errors = 0;
   res_t sb[$];
   res_t got[$];
   int got_rd = 0;

   // Memory model state (written only by the model process)
   bit [7:0] mem_arr [1024];
   resp_t    pend[$];
   resp_t    r;
   logic [9:0] a;
   int cyc = 0, n_ld = 0, n_st = 0, released = 0, inject_done = 0;
   // Memory model controls (written only by the stimulus process)
   bit stall = 1'b0;
   int release_tgt = 0;
   int inject_req = 0;

   // In-order memory: requests sampled after the edge, responses after LAT cycles
   always @(posedge clk) begin
      #1;
      cyc++;
      mem_valid_in      = 1'b0;
      mem_load_store_in = 1'b0;
      mem_address_in    = '0;
      mem_load_value_in = '0;
      if (!reset) begin
         pend.delete();
      end else begin
         if (mem_valid) begin
            a      = mem_address[9:0];
            r.ls   = mem_load_store;
            r.addr = mem_address;
            r.due  = cyc + LAT;
            if (mem_load_store) begin
               n_ld++;
               r.val = mem_BMS ? {24'hA5A5A5, mem_arr[a]}
                               : {mem_arr[a+10'd3], mem_arr[a+10'd2], mem_arr[a+10'd1], mem_arr[a]};
            end else begin
               n_st++;
               r.val = '0;
               mem_arr[a] = mem_store_value[7:0];
               if (!mem_BMS) begin
                  mem_arr[a+10'd1] = mem_store_value[15:8];
                  mem_arr[a+10'd2] = mem_store_value[23:16];
                  mem_arr[a+10'd3] = mem_store_value[31:24];
               end
            end
            pend.push_back(r);
         end
         if (inject_done < inject_req) begin
            inject_done++;
            mem_valid_in      = 1'b1;
            mem_load_store_in = 1'b1;
            mem_address_in    = 32'h300;
            mem_load_value_in = 32'h12345678;
         end else if (pend.size() > 0 && pend[0].due <= cyc && (!stall || released < release_tgt)) begin
            if (stall) released++;
            mem_valid_in      = 1'b1;
            mem_load_store_in = pend[0].ls;
            mem_address_in    = pend[0].addr;
            mem_load_value_in = pend[0].val;
            void'(pend.pop_front());
         end
      end
   end

   // Result capture away from the active edge
   always @(negedge clk) begin
      if (reset && result_valid) got.push_back('{result_tag, result_is_load, result_value});
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Called at a negedge; holds the request until a clock edge transfers it
   task automatic send(input logic ls, input logic bms, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data, input logic [TAG_W-1:0] tag);
      int n = 0;
      req_load_store  = ls;
      req_BMS         = bms;
      req_signed      = sgn;
      req_address     = addr;
      req_store_value = data;
      req_tag         = tag;
      req_valid       = 1'b1;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("send_accepted", 64'(n < 200), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Compare every expected result against captured results, in order
   task automatic drain(input string name);
      int t = 0;
      res_t e, g;
      while (sb.size() > 0 && t < 500) begin
         if (got_rd < got.size()) begin
            e = sb.pop_front();
            g = got[got_rd];
            got_rd++;
            checks++;
            assert ({g.tag, g.is_load, g.value} === {e.tag, e.is_load, e.value}) else begin
               errors++;
               $error("FAIL %s: tag/is_load/value observed %0h/%0b/%08h expected %0h/%0b/%08h",
                      name, g.tag, g.is_load, g.value, e.tag, e.is_load, e.value);
            end
         end else begin
            @(negedge clk);
            t++;
         end
      end
      chk({name, "_all_returned"}, 64'(sb.size()), 64'd0);
      repeat (4) @(negedge clk);
      chk({name, "_no_extra"}, 64'(got.size() - got_rd), 64'd0);
   endtask

   int ld0, st0, t;
   bit saw_ready;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {req_ready, mem_valid, result_valid, proto_error}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(req_ready), 64'd1);

      // Word store then word load
      send(1'b0, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF, 6'd3);
      sb.push_back('{6'd3, 1'b0, 32'h0});
      send(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 6'd4);
      sb.push_back('{6'd4, 1'b1, 32'hDEADBEEF});
      drain("word_st_ld");

      // Byte store through read-modify-write
      ld0 = n_ld;
      st0 = n_st;
      send(1'b0, 1'b1, 1'b0, 32'h41, 32'h123456AB, 6'd5);
      sb.push_back('{6'd5, 1'b0, 32'h0});
      saw_ready = 1'b0;
      t = 0;
      while (n_st == st0 && t < 100) begin
         if (req_ready) saw_ready = 1'b1;
         @(negedge clk);
         t++;
      end
      chk("rmw_ready_low", 64'(saw_ready), 64'd0);
      drain("rmw_result");
      chk("rmw_one_load", 64'(n_ld - ld0), 64'd1);
      chk("rmw_one_store", 64'(n_st - st0), 64'd1);
      send(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 6'd6);
      sb.push_back('{6'd6, 1'b1, 32'hDEADABEF});
      send(1'b1, 1'b1, 1'b1, 32'h41, 32'h0, 6'd7);
      sb.push_back('{6'd7, 1'b1, 32'hFFFFFFAB});
      send(1'b1, 1'b1, 1'b0, 32'h41, 32'h0, 6'd8);
      sb.push_back('{6'd8, 1'b1, 32'h000000AB});
      drain("after_rmw_loads");

      // Fill a table, then load it back with memory stalled
      for (int i = 0; i < 16; i++) begin
         send(1'b0, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 6'(10 + i));
         sb.push_back('{6'(10 + i), 1'b0, 32'h0});
      end
      drain("table_stores");
      stall = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 6'(30 + i));
         sb.push_back('{6'(30 + i), 1'b1, 32'hC0DE0000 + 32'(i)});
      end
      repeat (3) @(negedge clk);
      chk("ready_low_full", 64'(req_ready), 64'd0);
      release_tgt = 1;
      @(negedge clk);
      chk("ready_low_before_pop", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("ready_high_after_pop", 64'(req_ready), 64'd1);
      stall = 1'b0;
      drain("stall_order");

      // Response with nothing outstanding
      chk("no_error_yet", 64'(proto_error), 64'd0);
      inject_req = 1;
      repeat (3) @(negedge clk);
      chk("proto_error_set", 64'(proto_error), 64'd1);
      chk("inject_no_result", 64'(got.size() - got_rd), 64'd0);
      repeat (6) @(negedge clk);
      chk("proto_error_sticky", 64'(proto_error), 64'd1);

      // Reset with requests in flight
      stall = 1'b1;
      for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 6'(50 + i));
      reset = 1'b0;
      #1;
      chk("rst_mid_ctrl", {result_value, result_tag, result_is_load, result_valid,
                           req_ready, mem_valid, mem_load_store, mem_BMS, proto_error}, 64'd0);
      chk("rst_mid_mem", {mem_address, mem_store_value}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      sb.delete();
      got_rd = got.size();
      stall = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready), 64'd1);
      chk("post_rst_error", 64'(proto_error), 64'd0);
      send(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 6'd60);
      sb.push_back('{6'd60, 1'b1, 32'hDEADABEF});
      drain("post_rst_load");
      chk("post_rst_clean", 64'(proto_error), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
